// File: rtl/display_port_periph_pkg.sv
// Shared constants for the KCPSM6 display peripheral: register offsets,
// CTRL/STATUS bit positions and active-high 7-segment glyphs (seg[0] = a).
package display_pkg;

  localparam logic [7:0] DIGIT0_OFS = 8'd0;
  localparam logic [7:0] DIGIT1_OFS = 8'd1;
  localparam logic [7:0] DIGIT2_OFS = 8'd2;
  localparam logic [7:0] DIGIT3_OFS = 8'd3;
  localparam logic [7:0] CTRL_OFS   = 8'd4;
  localparam logic [7:0] STATUS_OFS = 8'd5;

  localparam int unsigned CTRL_SCAN_EN      = 32'd0;
  localparam int unsigned CTRL_IRQ_EN       = 32'd1;
  localparam int unsigned STATUS_FRAME_DONE = 32'd0;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/display_port_periph_if.sv
// KCPSM6 port bus as seen between the processor (master) and a peripheral (slave).
interface display_port_periph_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/display_port_periph_hex7seg.sv
// Hex nibble to active-high 7-segment pattern; polarity is applied by the parent.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Glyph lookup
  always_comb begin
    seg_o = 7'h00;
    case (hex_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_port_periph.sv
// KCPSM6 port-bus peripheral: four digit registers, control/status, a
// multiplexed 4-digit 7-segment driver and a frame-done interrupt.
module display_port_periph
  import display_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_port_periph_if.slave bus,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic [7:0]  digit_q [4];
  logic [7:0]  digit_d [4];
  logic [7:0]  ctrl_q, ctrl_d;
  logic        frame_done_q, frame_done_d;
  logic        irq_q, irq_d;
  logic [7:0]  in_port_q, in_port_d;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [7:0]  ofs_s;
  logic        scan_en_s, tick_s, wrap_s, status_clr_s, lit_s;
  logic [3:0]  cur_nib_s, blank_s, an_on_s;
  logic        cur_dp_s;
  logic [6:0]  hex_seg_s;
  logic        rd_strobe_unused;

  // Offsets wrap modulo 256, so anything outside 0..5 is unmapped
  assign ofs_s            = bus.port_id - BASE_ADDR;
  assign scan_en_s        = ctrl_q[CTRL_SCAN_EN];
  assign blank_s          = ctrl_q[7:4];
  assign tick_s           = scan_en_s && (presc_q == (SCAN_DIV - 16'd1));
  assign wrap_s           = tick_s && (idx_q == 2'd3);
  assign status_clr_s     = bus.write_strobe && (ofs_s == STATUS_OFS)
                            && bus.out_port[STATUS_FRAME_DONE];
  assign cur_nib_s        = digit_q[idx_q][3:0];
  assign cur_dp_s         = digit_q[idx_q][7];
  assign lit_s            = scan_en_s && !blank_s[idx_q];
  assign an_on_s          = lit_s ? (4'b0001 << idx_q) : 4'b0000;
  assign rd_strobe_unused = bus.read_strobe;

  hex7seg u_hex7seg (
    .hex_i (cur_nib_s),
    .seg_o (hex_seg_s)
  );

  // Register writes, scan counters, sticky flags and read mux
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      digit_d[i] = (bus.write_strobe && (ofs_s == 8'(i))) ? bus.out_port : digit_q[i];
    end
    ctrl_d = (bus.write_strobe && (ofs_s == CTRL_OFS)) ? bus.out_port : ctrl_q;

    presc_d = 16'd0;
    idx_d   = 2'd0;
    if (!scan_en_s) begin
      presc_d = 16'd0;
      idx_d   = 2'd0;
    end else if (tick_s) begin
      presc_d = 16'd0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
    end

    // A new frame wrap beats a coincident clear or acknowledge
    frame_done_d = frame_done_q;
    if (wrap_s) begin
      frame_done_d = 1'b1;
    end else if (status_clr_s) begin
      frame_done_d = 1'b0;
    end else begin
      frame_done_d = frame_done_q;
    end

    irq_d = irq_q;
    if (wrap_s && ctrl_q[CTRL_IRQ_EN]) begin
      irq_d = 1'b1;
    end else if (bus.interrupt_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    in_port_d = 8'h00;
    case (ofs_s)
      DIGIT0_OFS: in_port_d = digit_q[0];
      DIGIT1_OFS: in_port_d = digit_q[1];
      DIGIT2_OFS: in_port_d = digit_q[2];
      DIGIT3_OFS: in_port_d = digit_q[3];
      CTRL_OFS:   in_port_d = ctrl_q;
      STATUS_OFS: in_port_d = {4'b0000, idx_q, irq_q, frame_done_q};
      default:    in_port_d = 8'h00;
    endcase

    an_d  = SEG_ACTIVE_LOW ? ~an_on_s : an_on_s;
    seg_d = lit_s ? (SEG_ACTIVE_LOW ? ~hex_seg_s : hex_seg_s) : SEG_OFF;
    dp_d  = lit_s ? (SEG_ACTIVE_LOW ? ~cur_dp_s : cur_dp_s) : DP_OFF;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= 8'h00;
      end
      ctrl_q       <= 8'h00;
      frame_done_q <= 1'b0;
      irq_q        <= 1'b0;
      in_port_q    <= 8'h00;
      presc_q      <= 16'd0;
      idx_q        <= 2'd0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= digit_d[i];
      end
      ctrl_q       <= ctrl_d;
      frame_done_q <= frame_done_d;
      irq_q        <= irq_d;
      in_port_q    <= in_port_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;
  assign an            = an_q;
  assign seg           = seg_q;
  assign dp            = dp_q;

endmodule

// File: tb/tb_display_port_periph.sv
// Scoreboard bench for display_port_periph with BASE_ADDR=8'h10, SCAN_DIV=4, active-low drive.
module tb_display_port_periph;

  localparam logic [7:0] BASE = 8'h10;
  localparam int         DIV  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  display_port_periph_if bus ();

  display_port_periph #(
    .BASE_ADDR      (BASE),
    .SCAN_DIV       (16'd4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t       exp_q [$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         k = 0;
  logic [7:0] m_digit [4];
  logic [7:0] m_ctrl;

  task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk_val("sb_empty", 16'(exp_q.size()), 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk_val(e.tag, got, e.val);
    end
  endtask

  function automatic logic [6:0] seg_hi(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[h];
  endfunction

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] o;
    o = a - BASE;
    bus.port_id      = a;
    bus.out_port     = d;
    bus.write_strobe = 1'b1;
    step();
    bus.write_strobe = 1'b0;
    if (o < 8'd4) m_digit[o[1:0]] = d;
    else if (o == 8'd4) m_ctrl = d;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.port_id     = a;
    bus.read_strobe = 1'b1;
    push_exp(tag, {8'h00, exp});
    step();
    bus.read_strobe = 1'b0;
    pop_chk({8'h00, bus.in_port});
  endtask

  // k counts edges since the enabling CTRL write; digit shown after edge k+1 is (k/DIV)%4
  task automatic scan_check(input string tag, input int n);
    int   d;
    logic lit;
    for (int i = 0; i < n; i++) begin
      d   = (k / DIV) % 4;
      lit = !m_ctrl[4 + d];
      push_exp({tag, "_an"},  lit ? {12'd0, ~(4'b0001 << d)} : 16'h000F);
      push_exp({tag, "_seg"}, lit ? {9'd0, ~seg_hi(m_digit[d][3:0])} : 16'h007F);
      push_exp({tag, "_dp"},  lit ? {15'd0, ~m_digit[d][7]} : 16'h0001);
      step();
      pop_chk({12'd0, an});
      pop_chk({9'd0, seg});
      pop_chk({15'd0, dp});
    end
  endtask

  initial begin
    bus.port_id       = 8'h00;
    bus.out_port      = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;
    for (int i = 0; i < 4; i++) m_digit[i] = 8'h00;
    m_ctrl = 8'h00;

    repeat (3) @(negedge clk);
    chk_val("rst_in_port", {8'h00, bus.in_port}, 16'h0000);
    chk_val("rst_irq", {15'd0, bus.interrupt}, 16'h0000);
    chk_val("rst_an", {12'd0, an}, 16'h000F);
    chk_val("rst_seg", {9'd0, seg}, 16'h007F);
    chk_val("rst_dp", {15'd0, dp}, 16'h0001);
    reset_n = 1'b1;
    step();

    // Register access and address decode
    wr(BASE + 8'd2, 8'h8A);
    rd("rd_digit2", BASE + 8'd2, 8'h8A);
    rd("rd_base7", BASE + 8'd7, 8'h00);
    rd("rd_below_base", BASE - 8'd1, 8'h00);
    wr(BASE + 8'd6, 8'hFF);
    wr(BASE + 8'hF0, 8'h55);
    rd("rd_base6", BASE + 8'd6, 8'h00);
    rd("rd_digit0_untouched", BASE, 8'h00);
    wr(BASE + 8'd4, 8'hFC);
    rd("rd_ctrl", BASE + 8'd4, 8'hFC);
    wr(BASE + 8'd0, 8'h01);
    wr(BASE + 8'd1, 8'h72);
    wr(BASE + 8'd2, 8'h83);
    wr(BASE + 8'd3, 8'h04);
    rd("rd_digit0", BASE + 8'd0, 8'h01);
    rd("rd_digit1", BASE + 8'd1, 8'h72);
    rd("rd_digit2b", BASE + 8'd2, 8'h83);
    rd("rd_digit3", BASE + 8'd3, 8'h04);

    // Plain scan, interrupt disabled
    wr(BASE + 8'd4, 8'h01);
    k = 0;
    scan_check("scan", 20);
    chk_val("scan_no_irq", {15'd0, bus.interrupt}, 16'h0000);
    wr(BASE + 8'd4, 8'h00);
    step();
    chk_val("off_an", {12'd0, an}, 16'h000F);
    rd("status_fd", BASE + 8'd5, 8'h01);
    wr(BASE + 8'd5, 8'hFE);
    rd("status_noclr", BASE + 8'd5, 8'h01);
    wr(BASE + 8'd5, 8'h01);
    rd("status_clr", BASE + 8'd5, 8'h00);

    // Interrupt rises on the first 3->0 wrap (16 edges at DIV=4)
    wr(BASE + 8'd4, 8'h03);
    k = 0;
    for (int i = 0; i < 17; i++) begin
      push_exp("irq_rise", (k + 1 >= 16) ? 16'd1 : 16'd0);
      step();
      pop_chk({15'd0, bus.interrupt});
    end
    rd("status_irq", BASE + 8'd5, 8'h03);
    bus.interrupt_ack = 1'b1;
    step();
    bus.interrupt_ack = 1'b0;
    chk_val("irq_ack", {15'd0, bus.interrupt}, 16'h0000);
    wr(BASE + 8'd5, 8'h01);
    rd("status_after_clr", BASE + 8'd5, 8'h04);

    // Ack and STATUS clear both coincide with the wrap at edge 32
    while (k < 31) step();
    chk_val("pre_collide_irq", {15'd0, bus.interrupt}, 16'h0000);
    bus.interrupt_ack = 1'b1;
    wr(BASE + 8'd5, 8'h01);
    bus.interrupt_ack = 1'b0;
    chk_val("collide_irq", {15'd0, bus.interrupt}, 16'h0001);
    rd("collide_status", BASE + 8'd5, 8'h03);
    wr(BASE + 8'd4, 8'h01);
    chk_val("irq_en_clr_keeps", {15'd0, bus.interrupt}, 16'h0001);
    bus.interrupt_ack = 1'b1;
    step();
    bus.interrupt_ack = 1'b0;
    chk_val("irq_ack2", {15'd0, bus.interrupt}, 16'h0000);

    // Blank digits 0 and 2
    wr(BASE + 8'd4, 8'h00);
    step();
    wr(BASE + 8'd4, 8'h51);
    k = 0;
    scan_check("blank", 20);
    chk_val("blank_no_irq", {15'd0, bus.interrupt}, 16'h0000);
    wr(BASE + 8'd4, 8'h00);
    step();
    chk_val("dis_an", {12'd0, an}, 16'h000F);
    rd("dis_status", BASE + 8'd5, 8'h01);

    // Asynchronous reset in the middle of scanning with an interrupt pending
    wr(BASE + 8'd4, 8'h03);
    k = 0;
    while (k < 18) step();
    chk_val("pre_rst_irq", {15'd0, bus.interrupt}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk_val("arst_an", {12'd0, an}, 16'h000F);
    chk_val("arst_seg", {9'd0, seg}, 16'h007F);
    chk_val("arst_dp", {15'd0, dp}, 16'h0001);
    chk_val("arst_irq", {15'd0, bus.interrupt}, 16'h0000);
    chk_val("arst_in_port", {8'h00, bus.in_port}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) m_digit[i] = 8'h00;
    m_ctrl = 8'h00;
    rd("post_rst_digit2", BASE + 8'd2, 8'h00);
    rd("post_rst_ctrl", BASE + 8'd4, 8'h00);
    chk_val("post_rst_an", {12'd0, an}, 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
